// File: rtl/wb_burst_master_pkg.sv
// Shared definitions for the Wishbone burst master.
//   state_t     : controller states
//   CTI_*       : Wishbone B3 cycle-type identifier encodings
//   BEAT_CNT_W  : default width of the command beat-count field
package wb_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_WR,
    ST_RD,
    ST_FIN,
    ST_ABORT
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int unsigned BEAT_CNT_W = 4;

endpackage

// File: rtl/wb_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and the memory-controller slave.
//   master modport : drives cyc/stb/we/addr/dat/sel/cti, receives ack and read data
//   slave modport  : the mirror image
interface wb_burst_master_if #(
  parameter int unsigned dw     = 32,
  parameter int unsigned APP_AW = 26
);

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [APP_AW-1:0] wb_addr_o;
  logic [dw-1:0]     wb_dat_o;
  logic [dw/8-1:0]   wb_sel_o;
  logic [2:0]        wb_cti_o;
  logic              wb_ack_i;
  logic [dw-1:0]     wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );

endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 initiator: converts (address, beat count, direction) commands into
// incrementing-burst cycles towards the SDRAM memory controller.
//   wb_clk_i / wb_rst_i     : clock, asynchronous active-high reset
//   cmd_*                   : command offer (valid/ready), direction, start address,
//                             beats-1, byte enables for all beats
//   wr_data_i/valid/ready   : write beat stream into the master
//   rd_data_o / rd_valid_o  : registered read beats, one-cycle strobe, no back-pressure
//   done_o / err_o          : one-cycle end-of-burst pulses (normal / slave timeout)
//   busy_o                  : command in progress
//   wb                      : Wishbone master bus bundle
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int unsigned dw     = 32,
  parameter int unsigned APP_AW = 26,
  parameter int unsigned LEN_W  = BEAT_CNT_W,
  parameter int unsigned TMO    = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [APP_AW-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [dw/8-1:0]   cmd_sel_i,
  input  logic [dw-1:0]     wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [dw-1:0]     rd_data_o,
  output logic              rd_valid_o,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o,
  wb_burst_master_if.master wb
);

  localparam int unsigned       TMO_W     = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO - 1);
  localparam logic [APP_AW-1:0] ADDR_STEP = APP_AW'(dw / 8);

  state_t state, state_nxt;

  logic              we_q;
  logic [APP_AW-1:0] addr_q;
  logic [dw/8-1:0]   sel_q;
  logic [dw-1:0]     dat_q;
  logic [LEN_W-1:0]  beats_left;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [dw-1:0]     rd_data_q;
  logic              rd_valid_q;

  logic cyc, stb;
  logic ack, last_beat, tmo_hit;
  logic cmd_take, wr_take;

  // ack only counts while a strobe is actually presented
  assign ack       = ((state == ST_WR) || (state == ST_RD)) && wb.wb_ack_i;
  assign last_beat = (beats_left == '0);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign cmd_take  = cmd_ready_o && cmd_valid_i;
  assign wr_take   = wr_ready_o && wr_valid_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    cyc         = 1'b0;
    stb         = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state)
      ST_IDLE: begin
        // held low while reset is asserted so every output reads 0 during reset
        cmd_ready_o = ~wb_rst_i;
        if (cmd_valid_i) begin
          state_nxt = cmd_we_i ? ST_WR_WAIT : ST_RD;
        end
      end
      ST_WR_WAIT: begin
        cyc        = 1'b1;
        wr_ready_o = 1'b1;
        if (wr_valid_i) begin
          state_nxt = ST_WR;
        end
      end
      ST_WR: begin
        cyc = 1'b1;
        stb = 1'b1;
        if (wb.wb_ack_i) begin
          if (last_beat) begin
            state_nxt = ST_FIN;
          end else begin
            // next beat may be taken in the ack cycle for a zero-bubble burst
            wr_ready_o = 1'b1;
            if (!wr_valid_i) begin
              state_nxt = ST_WR_WAIT;
            end
          end
        end else if (tmo_hit) begin
          state_nxt = ST_ABORT;
        end
      end
      ST_RD: begin
        cyc = 1'b1;
        stb = 1'b1;
        if (wb.wb_ack_i) begin
          if (last_beat) begin
            state_nxt = ST_FIN;
          end
        end else if (tmo_hit) begin
          state_nxt = ST_ABORT;
        end
      end
      ST_FIN: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ABORT: begin
        err_o     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      dat_q      <= '0;
      beats_left <= '0;
      tmo_cnt    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (cmd_take) begin
        we_q       <= cmd_we_i;
        addr_q     <= cmd_addr_i;
        sel_q      <= cmd_sel_i;
        beats_left <= cmd_len_i;
      end
      if (wr_take) begin
        dat_q <= wr_data_i;
      end
      if (ack) begin
        addr_q <= addr_q + ADDR_STEP;
        if (!last_beat) begin
          beats_left <= beats_left - 1'b1;
        end
        if (!we_q) begin
          rd_data_q  <= wb.wb_dat_i;
          rd_valid_q <= 1'b1;
        end
      end
      if (stb && !ack) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  assign wb.wb_cyc_o  = cyc;
  assign wb.wb_stb_o  = stb;
  assign wb.wb_we_o   = cyc && we_q;
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_dat_o  = dat_q;
  assign wb.wb_sel_o  = sel_q;
  assign wb.wb_cti_o  = !cyc ? CTI_CLASSIC : (last_beat ? CTI_EOB : CTI_INCR);

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = (state != ST_IDLE);

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: randomized slave acks, directed and random
// bursts, behavioural bus model checked every cycle plus literal spot checks.
module tb_wb_burst_master;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 26;
  localparam int unsigned LW  = 4;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready_o, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [3:0]    cmd_sel;
  logic [DW-1:0] wr_data;
  logic          wr_valid, wr_ready_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o, done_o, err_o, busy_o;

  wb_burst_master_if #(.dw(DW), .APP_AW(AW)) wb ();

  wb_burst_master #(.dw(DW), .APP_AW(AW), .LEN_W(LW), .TMO(TMO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we),
    .cmd_addr_i (cmd_addr),
    .cmd_len_i  (cmd_len),
    .cmd_sel_i  (cmd_sel),
    .wr_data_i  (wr_data),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready_o),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .busy_o     (busy_o),
    .wb         (wb.master)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fill(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
    end
    return r;
  endfunction

  // ---------------- slave: random acks, own memory ----------------
  logic [31:0] slv_mem [logic [AW-1:0]];
  int ack_pct = 100;

  always @(posedge clk) begin
    logic [AW-1:0] a;
    logic [31:0]   old;
    #1;
    wb.wb_ack_i = 1'b0;
    wb.wb_dat_i = $urandom;
    if (!rst && wb.wb_stb_o && ($urandom_range(0, 99) < ack_pct)) begin
      wb.wb_ack_i = 1'b1;
      a   = wb.wb_addr_o;
      old = slv_mem.exists(a) ? slv_mem[a] : fill(a);
      if (wb.wb_we_o) slv_mem[a] = merge(old, wb.wb_dat_o, wb.wb_sel_o);
      else            wb.wb_dat_i = old;
    end
  end

  // ---------------- behavioural model + compare ----------------
  logic [31:0]   ref_mem [logic [AW-1:0]];
  bit            m_active = 0;
  logic          m_we;
  logic [AW-1:0] m_addr0;
  logic [3:0]    m_sel;
  int            m_len, m_beat, m_taken, m_wait;
  logic [31:0]   m_wq [$];
  bit            exp_rdv = 0, exp_done = 0, exp_err = 0;
  logic [31:0]   exp_rdd;
  // per-burst records for literal checks
  logic [AW-1:0] rec_addr [$];
  logic [2:0]    rec_cti [$];
  logic [31:0]   rec_dat [$];
  logic [31:0]   rec_rd [$];
  int            stb_cycles = 0;

  task automatic check_zero(input string tag);
    check({tag, "_cyc"},   wb.wb_cyc_o, 0);
    check({tag, "_stb"},   wb.wb_stb_o, 0);
    check({tag, "_we"},    wb.wb_we_o, 0);
    check({tag, "_cti"},   wb.wb_cti_o, 0);
    check({tag, "_addr"},  wb.wb_addr_o, 0);
    check({tag, "_sel"},   wb.wb_sel_o, 0);
    check({tag, "_dat"},   wb.wb_dat_o, 0);
    check({tag, "_rdv"},   rd_valid_o, 0);
    check({tag, "_done"},  done_o, 0);
    check({tag, "_err"},   err_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_cmdrdy"}, cmd_ready_o, 0);
    check({tag, "_wrrdy"}, wr_ready_o, 0);
  endtask

  always @(negedge clk) begin
    bit            e_busy, e_stb, e_ack, last, e_wrdy, wr_tk;
    logic [AW-1:0] ea;
    logic [31:0]   old;
    if (rst) begin
      check_zero("rst");
      m_active = 0; exp_rdv = 0; exp_done = 0; exp_err = 0;
    end else begin
      e_busy = m_active || exp_done || exp_err;
      check("rd_valid", rd_valid_o, exp_rdv);
      if (exp_rdv) begin
        check("rd_data", rd_data_o, exp_rdd);
        rec_rd.push_back(rd_data_o);
      end
      check("done", done_o, exp_done);
      check("err", err_o, exp_err);
      check("busy", busy_o, e_busy);
      check("cmd_ready", cmd_ready_o, !e_busy);
      check("cyc", wb.wb_cyc_o, m_active);
      check("we", wb.wb_we_o, m_active && m_we);
      // a write strobe exists exactly while a taken beat is still unacknowledged
      e_stb = m_active && (!m_we || (m_taken > m_beat));
      check("stb", wb.wb_stb_o, e_stb);
      e_ack = e_stb && wb.wb_ack_i;
      last  = (m_beat == m_len);
      e_wrdy = m_active && m_we &&
               ((m_taken == m_beat) || (e_ack && (m_taken == m_beat + 1) && !last));
      check("wr_ready", wr_ready_o, e_wrdy);
      wr_tk = e_wrdy && wr_valid;
      exp_rdv = 0; exp_done = 0; exp_err = 0;
      if (e_stb) begin
        ea = m_addr0 + AW'(m_beat * 4);
        stb_cycles++;
        check("addr", wb.wb_addr_o, ea);
        check("cti", wb.wb_cti_o, last ? 3'b111 : 3'b010);
        check("sel", wb.wb_sel_o, m_sel);
        if (m_we && (m_beat < m_wq.size())) check("wdat", wb.wb_dat_o, m_wq[m_beat]);
        if (e_ack) begin
          rec_addr.push_back(wb.wb_addr_o);
          rec_cti.push_back(wb.wb_cti_o);
          rec_dat.push_back(wb.wb_dat_o);
          old = ref_mem.exists(ea) ? ref_mem[ea] : fill(ea);
          if (m_we) begin
            if (m_beat < m_wq.size()) ref_mem[ea] = merge(old, m_wq[m_beat], m_sel);
          end else begin
            exp_rdv = 1;
            exp_rdd = old;
          end
          m_beat++;
          m_wait = 0;
          if (last) begin
            m_active = 0;
            exp_done = 1;
          end
        end else begin
          m_wait++;
          if (m_wait == TMO) begin
            m_active = 0;
            exp_err  = 1;
          end
        end
      end else begin
        m_wait = 0;
      end
      if (wr_tk) begin
        m_wq.push_back(wr_data);
        m_taken++;
      end
      if (!e_busy && cmd_valid) begin
        m_active = 1; m_we = cmd_we; m_addr0 = cmd_addr; m_sel = cmd_sel;
        m_len = int'(cmd_len); m_beat = 0; m_taken = 0; m_wait = 0;
        m_wq.delete();
        rec_addr.delete(); rec_cti.delete(); rec_dat.delete(); rec_rd.delete();
        stb_cycles = 0;
      end
    end
  end

  // ---------------- sequencer ----------------
  logic [31:0] wdata_q [$];

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input int len,
                          input logic [3:0] sel);
    bit acc;
    acc = 0;
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_len = LW'(len); cmd_sel = sel;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk); acc = cmd_ready_o;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    check("cmd_accept", acc, 1);
  endtask

  task automatic send_wdata(input int len, input int gap, output bit aborted);
    bit took;
    aborted = 0;
    for (int b = 0; b <= len && !aborted; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap && !aborted; g++) begin
          @(negedge clk); if (err_o) aborted = 1;
          @(posedge clk); #1;
        end
      end
      if (!aborted) begin
        took = 0; wr_valid = 1; wr_data = wdata_q[b];
        for (int i = 0; i < 200 && !took && !aborted; i++) begin
          @(negedge clk); took = wr_ready_o; if (err_o) aborted = 1;
          @(posedge clk); #1;
        end
        wr_valid = 0;
        if (!aborted) check("wr_beat_taken", took, 1);
      end
    end
  endtask

  task automatic wait_end(output bit got_done, output bit got_err);
    got_done = 0; got_err = 0;
    for (int i = 0; i < 1000 && !got_done && !got_err; i++) begin
      @(negedge clk); got_done = done_o; got_err = err_o;
      @(posedge clk); #1;
    end
    check("burst_end", got_done || got_err, 1);
  endtask

  task automatic run_burst(input logic we, input logic [AW-1:0] a, input int len,
                           input logic [3:0] sel, input int gap, input int pct,
                           output bit d, output bit e);
    bit ab;
    ack_pct = pct;
    ab = 0;
    send_cmd(we, a, len, sel);
    if (we) send_wdata(len, gap, ab);
    if (ab) begin
      d = 0; e = 1;
    end else begin
      wait_end(d, e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit          d, e;
    logic [31:0] saved [$];
    logic [AW-1:0] a;
    int          len;
    logic [3:0]  sel;

    rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0; cmd_sel = '0;
    wr_valid = 0; wr_data = '0; wb.wb_ack_i = 0; wb.wb_dat_i = '0;
    #1 check_zero("init");
    repeat (3) @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready_o, 1);
    @(posedge clk); #1;

    // 1: single write
    wdata_q = '{32'hDEAD_BEEF};
    run_burst(1, 26'h100, 0, 4'hF, 0, 100, d, e);
    check("t1_done", d, 1);
    check("t1_cti", rec_cti[0], 3'b111);
    check("t1_dat", rec_dat[0], 32'hDEAD_BEEF);
    check("t1_addr", rec_addr[0], 26'h100);
    check("t1_stb_cycles", stb_cycles, 1);

    // 2: 8-beat zero-bubble write
    wdata_q.delete();
    for (int i = 0; i < 8; i++) wdata_q.push_back($urandom);
    saved = wdata_q;
    run_burst(1, 26'h200, 7, 4'hF, 0, 100, d, e);
    check("t2_done", d, 1);
    check("t2_stb_cycles", stb_cycles, 8);
    for (int i = 0; i < 8; i++) begin
      check("t2_addr", rec_addr[i], 26'h200 + 26'(4 * i));
      check("t2_cti", rec_cti[i], (i == 7) ? 3'b111 : 3'b010);
    end

    // 3: read back
    run_burst(0, 26'h200, 7, 4'hF, 0, 100, d, e);
    check("t3_done", d, 1);
    check("t3_rd_count", rec_rd.size(), 8);
    for (int i = 0; i < 8 && i < rec_rd.size(); i++) check("t3_rd_data", rec_rd[i], saved[i]);

    // 4: gapped write
    wdata_q.delete();
    for (int i = 0; i < 4; i++) wdata_q.push_back($urandom);
    run_burst(1, 26'h300, 3, 4'hF, 3, 100, d, e);
    check("t4_done", d, 1);
    check("t4_stb_cycles", stb_cycles, 4);
    for (int i = 0; i < 4; i++) check("t4_dat", rec_dat[i], wdata_q[i]);

    // 5: slave never acks
    run_burst(0, 26'h400, 3, 4'hF, 0, 0, d, e);
    check("t5_err", e, 1);
    check("t5_stb_cycles", stb_cycles, TMO);
    wdata_q = '{32'h0BAD_F00D};
    run_burst(1, 26'h404, 0, 4'hF, 0, 100, d, e);
    check("t5_next_done", d, 1);

    // 6: reset mid read
    ack_pct = 100;
    send_cmd(0, 26'h200, 7, 4'hF);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1 check_zero("async_rst");
    repeat (2) @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    check("t6_cmd_ready", cmd_ready_o, 1);
    @(posedge clk); #1;

    // address wrap
    run_burst(0, 26'h3FF_FFFC, 1, 4'hF, 0, 100, d, e);
    check("wrap_done", d, 1);
    check("wrap_addr0", rec_addr[0], 26'h3FF_FFFC);
    check("wrap_addr1", rec_addr[1], 26'h0);

    // random bursts
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom);
      a[1:0] = 2'b00;
      if ($urandom_range(0, 4) == 0) a = 26'h3FF_FFFC - AW'(4 * $urandom_range(0, 3));
      len = $urandom_range(0, 15);
      sel = 4'($urandom_range(1, 15));
      wdata_q.delete();
      for (int i = 0; i <= len; i++) wdata_q.push_back($urandom);
      run_burst(1'($urandom_range(0, 1)), a, len, sel, $urandom_range(0, 3),
                $urandom_range(60, 100), d, e);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
